// File: rtl/eth_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter: four ingress streams share one registered output
// stage. A granted port keeps the output from SOP to EOP, so packets never interleave.
module eth_pkt_rr_arbiter #(
   parameter int DATA_W  = 148,
   parameter int EMPTY_W = 4,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [4*DATA_W-1:0]   in_data,
   input  logic [3:0]            in_valid,
   input  logic [3:0]            in_sop,
   input  logic [3:0]            in_eop,
   input  logic [4*EMPTY_W-1:0]  in_empty,
   output logic [3:0]            in_ready,
   input  logic                  xoff,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_valid,
   output logic                  out_sop,
   output logic                  out_eop,
   output logic [EMPTY_W-1:0]    out_empty,
   output logic [1:0]            out_channel,
   input  logic                  out_ready,
   output logic [4*CNT_W-1:0]    pkt_count,
   output logic                  sop_err,
   output logic                  o_dbg_state
);

   // Handshake: a beat moves on a cycle where valid and ready are both high at the
   // rising edge; a producer holds its beat stable while valid is high and ready is low.
   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [1:0]           r_grant;
   logic [1:0]           w_grant_nxt;
   logic [1:0]           r_last_grant;
   logic                 r_first_beat;
   logic                 r_sop_err;

   logic [DATA_W-1:0]    r_out_data;
   logic                 r_out_valid;
   logic                 r_out_sop;
   logic                 r_out_eop;
   logic [EMPTY_W-1:0]   r_out_empty;
   logic [1:0]           r_out_channel;
   logic [CNT_W-1:0]     r_pkt_cnt [4];

   logic                 w_load;
   logic                 w_accept;
   logic [3:0]           w_ready;
   logic                 w_pick_vld;
   logic [1:0]           w_pick;
   logic [DATA_W-1:0]    w_sel_data;
   logic                 w_sel_valid;
   logic                 w_sel_sop;
   logic                 w_sel_eop;
   logic [EMPTY_W-1:0]   w_sel_empty;

   assign w_load   = !r_out_valid || out_ready;
   assign w_accept = (r_state == ST_BUSY) && w_load && w_sel_valid;

   // Search last_grant+1 .. last_grant+4; iterating downwards lets the nearest port win.
   always_comb begin
      w_pick_vld = 1'b0;
      w_pick     = r_last_grant;
      for (int i = 4; i >= 1; i--) begin
         if (in_valid[r_last_grant + 2'(i)]) begin
            w_pick_vld = 1'b1;
            w_pick     = r_last_grant + 2'(i);
         end
      end
   end

   always_comb begin
      w_sel_data  = '0;
      w_sel_valid = 1'b0;
      w_sel_sop   = 1'b0;
      w_sel_eop   = 1'b0;
      w_sel_empty = '0;
      for (int p = 0; p < 4; p++) begin
         if (r_grant == 2'(p)) begin
            w_sel_data  = in_data[p*DATA_W +: DATA_W];
            w_sel_valid = in_valid[p];
            w_sel_sop   = in_sop[p];
            w_sel_eop   = in_eop[p];
            w_sel_empty = in_empty[p*EMPTY_W +: EMPTY_W];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_ready     = '0;
      case (r_state)
         ST_IDLE: begin
            if (!xoff && w_pick_vld) begin
               w_state_nxt = ST_BUSY;
               w_grant_nxt = w_pick;
            end
         end
         ST_BUSY: begin
            if (w_load) w_ready[r_grant] = 1'b1;
            if (w_accept && w_sel_eop) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_grant      <= 2'd0;
         r_last_grant <= 2'd3;
         r_first_beat <= 1'b0;
         r_sop_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         if (w_accept) begin
            r_first_beat <= 1'b0;
            if (r_first_beat && !w_sel_sop) r_sop_err <= 1'b1;
            if (w_sel_eop) r_last_grant <= r_grant;
         end
         if (r_state == ST_IDLE && w_state_nxt == ST_BUSY) r_first_beat <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_data    <= '0;
         r_out_valid   <= 1'b0;
         r_out_sop     <= 1'b0;
         r_out_eop     <= 1'b0;
         r_out_empty   <= '0;
         r_out_channel <= 2'd0;
      end else if (w_load) begin
         r_out_valid <= w_accept;
         if (w_accept) begin
            r_out_data    <= w_sel_data;
            r_out_sop     <= w_sel_sop;
            r_out_eop     <= w_sel_eop;
            r_out_empty   <= w_sel_empty;
            r_out_channel <= r_grant;
         end
      end
   end

   // Counters wrap naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < 4; p++) r_pkt_cnt[p] <= '0;
      end else if (w_accept && w_sel_eop) begin
         r_pkt_cnt[r_grant] <= r_pkt_cnt[r_grant] + 1'b1;
      end
   end

   for (genvar gp = 0; gp < 4; gp++) begin : g_cnt
      assign pkt_count[gp*CNT_W +: CNT_W] = r_pkt_cnt[gp];
   end

   assign in_ready    = w_ready;
   assign out_data    = r_out_data;
   assign out_valid   = r_out_valid;
   assign out_sop     = r_out_sop;
   assign out_eop     = r_out_eop;
   assign out_empty   = r_out_empty;
   assign out_channel = r_out_channel;
   assign sop_err     = r_sop_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_eth_pkt_rr_arbiter.sv
// Directed bench for eth_pkt_rr_arbiter: per-port packet sources, an in-order
// scoreboard on the output stage, and one task per scenario.
module tb_eth_pkt_rr_arbiter;
   localparam int DW = 148;
   localparam int EW = 4;
   localparam int CW = 8;
   localparam int BW = 2 + 1 + 1 + EW + DW;

   logic              clk;
   logic              reset_n;
   logic [4*DW-1:0]   in_data;
   logic [3:0]        in_valid;
   logic [3:0]        in_sop;
   logic [3:0]        in_eop;
   logic [4*EW-1:0]   in_empty;
   logic [3:0]        in_ready;
   logic              xoff;
   logic [DW-1:0]     out_data;
   logic              out_valid;
   logic              out_sop;
   logic              out_eop;
   logic [EW-1:0]     out_empty;
   logic [1:0]        out_channel;
   logic              out_ready;
   logic [4*CW-1:0]   pkt_count;
   logic              sop_err;
   logic              dbg_state;

   int checks = 0;
   int fails  = 0;

   logic [BW-1:0] exp_q[$];
   int            sop_chan[$];
   int            rem_pkts [4];
   int            cur_len  [4];
   int            beat_i   [4];
   int            fixed_len[4];
   bit            no_sop   [4];
   logic [DW-1:0] cur_data [4];
   logic [EW-1:0] cur_empty[4];
   bit            rdy_rand;
   bit            mon_flush;
   int            cyc;
   int            first_acc;
   int            last_acc;

   eth_pkt_rr_arbiter #(.DATA_W(DW), .EMPTY_W(EW), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
      .in_empty(in_empty), .in_ready(in_ready), .xoff(xoff),
      .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
      .out_empty(out_empty), .out_channel(out_channel), .out_ready(out_ready),
      .pkt_count(pkt_count), .sop_err(sop_err), .o_dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      fails++;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   // ---------------- source driver ----------------
   task automatic refresh_beat(input int p);
      logic [159:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      cur_data[p]  = t[DW-1:0];
      cur_empty[p] = EW'($urandom_range(0, 15));
   endtask

   task automatic start_port(input int p, input int n, input int len);
      rem_pkts[p]  = n;
      fixed_len[p] = len;
      beat_i[p]    = 0;
      cur_len[p]   = (len == 0) ? $urandom_range(1, 4) : len;
      refresh_beat(p);
   endtask

   task automatic clear_sources();
      for (int p = 0; p < 4; p++) begin
         rem_pkts[p] = 0;
         beat_i[p]   = 0;
         no_sop[p]   = 1'b0;
      end
      exp_q.delete();
      mon_flush = 1'b1;
   endtask

   initial begin
      in_data   = '0;
      in_valid  = '0;
      in_sop    = '0;
      in_eop    = '0;
      in_empty  = '0;
      out_ready = 1'b1;
      cyc       = 0;
      forever begin
         @(negedge clk);
         cyc++;
         out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         for (int p = 0; p < 4; p++) begin
            in_valid[p]          = (rem_pkts[p] > 0);
            in_sop[p]            = (beat_i[p] == 0) && !no_sop[p];
            in_eop[p]            = (beat_i[p] == cur_len[p] - 1);
            in_data[p*DW +: DW]  = cur_data[p];
            in_empty[p*EW +: EW] = cur_empty[p];
         end
         #1;
         checks++;
         if ($countones(in_ready) > 1) begin
            fails++;
            $display("FAIL ready_onehot: in_ready=%b, required at most one bit high", in_ready);
         end
         for (int p = 0; p < 4; p++) begin
            if (in_valid[p] && in_ready[p]) begin
               exp_q.push_back({2'(p), in_sop[p], in_eop[p], in_empty[p*EW +: EW], in_data[p*DW +: DW]});
               if (first_acc < 0) first_acc = cyc;
               last_acc = cyc;
               if (in_eop[p]) begin
                  rem_pkts[p]--;
                  beat_i[p]  = 0;
                  no_sop[p]  = 1'b0;
                  cur_len[p] = (fixed_len[p] == 0) ? $urandom_range(1, 4) : fixed_len[p];
               end else begin
                  beat_i[p]++;
               end
               refresh_beat(p);
            end
         end
      end
   end

   // ---------------- scoreboard / output monitor ----------------
   initial begin
      logic [BW-1:0] prev;
      logic [BW-1:0] cur;
      logic [BW-1:0] e;
      bit            prev_stall;
      prev_stall = 1'b0;
      prev       = '0;
      forever begin
         @(negedge clk);
         #2;
         if (mon_flush) begin
            prev_stall = 1'b0;
            mon_flush  = 1'b0;
         end
         cur = {out_channel, out_sop, out_eop, out_empty, out_data};
         if (prev_stall) begin
            checks++;
            if (cur !== prev || out_valid !== 1'b1) begin
               fails++;
               $display("FAIL stall_hold: out=%h valid=%b, required %h valid=1", cur, out_valid, prev);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL beat_unexpected: got %h, required no beat", cur);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e) begin
                  fails++;
                  $display("FAIL beat_data: got %h, required %h", cur, e);
               end
            end
            if (out_sop) sop_chan.push_back(int'(out_channel));
         end
         prev_stall = out_valid && !out_ready;
         prev       = cur;
      end
   end

   // ---------------- helpers ----------------
   task automatic do_reset();
      reset_n = 1'b0;
      xoff     = 1'b0;
      rdy_rand = 1'b0;
      clear_sources();
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
      @(posedge clk);
      #2;
   endtask

   task automatic wait_drain(input int budget, input string name);
      int n;
      n = 0;
      while ((rem_pkts[0] + rem_pkts[1] + rem_pkts[2] + rem_pkts[3] > 0 || exp_q.size() > 0
              || out_valid) && n < budget) begin
         @(posedge clk);
         #2;
         n++;
      end
      checks++;
      if (n >= budget) begin
         fails++;
         $display("FAIL %s_timeout: still busy after %0d cycles, required drained", name, n);
      end
   endtask

   task automatic check_cnt(input int p, input int expv, input string name);
      checks++;
      if (pkt_count[p*CW +: CW] !== CW'(expv)) begin
         fails++;
         $display("FAIL %s: pkt_count[%0d]=%0d, required %0d", name, p, pkt_count[p*CW +: CW], expv);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset_n = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_sop, out_eop, out_empty, out_channel, sop_err, in_ready, dbg_state} !== '0
          || out_data !== '0 || pkt_count !== '0) begin
         fails++;
         $display("FAIL reset_values: valid=%b sop=%b eop=%b empty=%h ch=%0d err=%b rdy=%b st=%b cnt=%h, required all 0",
                  out_valid, out_sop, out_eop, out_empty, out_channel, sop_err, in_ready, dbg_state, pkt_count);
      end
      do_reset();
   endtask

   task automatic test_single_port();
      logic expr;
      do_reset();
      start_port(0, 1, 8);
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         #3;
         expr = (c >= 1 && c <= 8);
         checks++;
         if (in_ready[0] !== expr) begin
            fails++;
            $display("FAIL single_ready c%0d: in_ready[0]=%b, required %b", c, in_ready[0], expr);
         end
         if (c == 2) begin
            checks++;
            if (out_valid !== 1'b1 || out_sop !== 1'b1 || out_channel !== 2'd0) begin
               fails++;
               $display("FAIL single_first_out: valid=%b sop=%b ch=%0d, required 1 1 0", out_valid, out_sop, out_channel);
            end
         end
         if (c == 9) begin
            checks++;
            if (out_valid !== 1'b1 || out_eop !== 1'b1) begin
               fails++;
               $display("FAIL single_last_out: valid=%b eop=%b, required 1 1", out_valid, out_eop);
            end
         end
         if (c == 10) begin
            checks++;
            if (out_valid !== 1'b0) begin
               fails++;
               $display("FAIL single_after: out_valid=%b, required 0", out_valid);
            end
         end
      end
      wait_drain(100, "single");
      check_cnt(0, 1, "single_cnt");
   endtask

   task automatic test_all_ports();
      do_reset();
      sop_chan.delete();
      first_acc = -1;
      for (int p = 0; p < 4; p++) start_port(p, 10, 4);
      wait_drain(1000, "allports");
      checks++;
      if (sop_chan.size() != 40) begin
         fails++;
         $display("FAIL rr_count: %0d packets seen, required 40", sop_chan.size());
      end
      for (int i = 0; i < sop_chan.size(); i++) begin
         checks++;
         if (sop_chan[i] != i % 4) begin
            fails++;
            $display("FAIL rr_order pkt%0d: channel %0d, required %0d", i, sop_chan[i], i % 4);
         end
      end
      checks++;
      if (last_acc - first_acc != 198) begin
         fails++;
         $display("FAIL rr_spacing: %0d cycles first-to-last beat, required 198", last_acc - first_acc);
      end
      for (int p = 0; p < 4; p++) check_cnt(p, 10, "rr_cnt");
   endtask

   task automatic test_xoff();
      int n;
      do_reset();
      sop_chan.delete();
      start_port(1, 1, 6);
      n = 0;
      while (beat_i[1] < 2 && n < 50) begin
         @(posedge clk);
         #2;
         n++;
      end
      xoff = 1'b1;
      start_port(0, 1, 2);
      start_port(2, 1, 2);
      n = 0;
      while (rem_pkts[1] > 0 && n < 50) begin
         @(posedge clk);
         #2;
         n++;
      end
      checks++;
      if (n >= 50) begin
         fails++;
         $display("FAIL xoff_truncate: port 1 packet not completed, required all 6 beats accepted");
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #3;
         checks++;
         if (dbg_state !== 1'b0 || in_ready !== 4'b0000) begin
            fails++;
            $display("FAIL xoff_hold c%0d: state=%b in_ready=%b, required 0 0000", c, dbg_state, in_ready);
         end
      end
      check_cnt(1, 1, "xoff_cnt1");
      @(posedge clk);
      #2;
      xoff = 1'b0;
      @(posedge clk);
      #2;
      checks++;
      if (dbg_state !== 1'b1 || in_ready !== 4'b0100) begin
         fails++;
         $display("FAIL xoff_regrant: state=%b in_ready=%b, required 1 0100", dbg_state, in_ready);
      end
      wait_drain(100, "xoff");
      checks++;
      if (sop_chan.size() != 3 || sop_chan[0] != 1 || sop_chan[1] != 2 || sop_chan[2] != 0) begin
         fails++;
         $display("FAIL xoff_order: %0d packets, required order 1,2,0", sop_chan.size());
      end
   endtask

   task automatic test_random_ready();
      do_reset();
      rdy_rand = 1'b1;
      for (int p = 0; p < 4; p++) start_port(p, 250, 0);
      wait_drain(30000, "random");
      rdy_rand = 1'b0;
      for (int p = 0; p < 4; p++) check_cnt(p, 250, "random_cnt");
   endtask

   task automatic test_sop_err();
      int n;
      do_reset();
      start_port(0, 1, 1);
      wait_drain(50, "soperr_pre");
      no_sop[3] = 1'b1;
      start_port(3, 1, 3);
      n = 0;
      while (beat_i[3] < 1 && n < 50) begin
         @(posedge clk);
         #2;
         n++;
      end
      checks++;
      if (sop_err !== 1'b1 || out_valid !== 1'b1 || out_channel !== 2'd3 || out_sop !== 1'b0) begin
         fails++;
         $display("FAIL sop_err_set: err=%b valid=%b ch=%0d sop=%b, required 1 1 3 0",
                  sop_err, out_valid, out_channel, out_sop);
      end
      check_cnt(0, 1, "soperr_cnt_pre");
      #1;
      reset_n = 1'b0;
      clear_sources();
      #1;
      checks++;
      if ({out_valid, out_sop, out_eop, out_empty, out_channel, sop_err, in_ready} !== '0
          || out_data !== '0 || pkt_count !== '0) begin
         fails++;
         $display("FAIL async_reset: valid=%b ch=%0d err=%b rdy=%b cnt=%h, required all 0",
                  out_valid, out_channel, sop_err, in_ready, pkt_count);
      end
      start_port(1, 1, 1);
      start_port(2, 1, 1);
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      @(posedge clk);
      #2;
      checks++;
      if (in_ready !== 4'b0010) begin
         fails++;
         $display("FAIL post_reset_grant: in_ready=%b, required 0010", in_ready);
      end
      wait_drain(100, "soperr_post");
   endtask

   task automatic test_wrap();
      do_reset();
      start_port(2, 255, 1);
      wait_drain(3000, "wrap_fill");
      check_cnt(2, 255, "wrap_full");
      start_port(2, 1, 1);
      wait_drain(50, "wrap");
      check_cnt(2, 0, "wrap_zero");
   endtask

   initial begin
      reset_n   = 1'b1;
      xoff      = 1'b0;
      rdy_rand  = 1'b0;
      mon_flush = 1'b0;
      first_acc = -1;
      last_acc  = 0;
      test_reset();
      test_single_port();
      test_all_ports();
      test_xoff();
      test_random_ready();
      test_sop_err();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
